// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU core and its operand collector.
package alu_pkg;

    localparam int DATA_WIDTH_DEF = 8;
    localparam int CMD_WIDTH_DEF  = 4;
    localparam int TIMEOUT_CYCLES = 16;
    localparam int WAIT_CNT_W     = $clog2(TIMEOUT_CYCLES);

    typedef logic [CMD_WIDTH_DEF-1:0] cmd_t;

    typedef enum logic [CMD_WIDTH_DEF-1:0] {
        CMD_ADD     = 4'd0,
        CMD_SUB     = 4'd1,
        CMD_ADD_CIN = 4'd2,
        CMD_SUB_CIN = 4'd3,
        CMD_INC_A   = 4'd4,
        CMD_DEC_A   = 4'd5,
        CMD_INC_B   = 4'd6,
        CMD_DEC_B   = 4'd7,
        CMD_CMP     = 4'd8,
        CMD_MUL_INC = 4'd9,
        CMD_MUL_SHL = 4'd10
    } arith_cmd_e;

    typedef enum logic [CMD_WIDTH_DEF-1:0] {
        CMD_AND     = 4'd0,
        CMD_NAND    = 4'd1,
        CMD_OR      = 4'd2,
        CMD_NOR     = 4'd3,
        CMD_XOR     = 4'd4,
        CMD_XNOR    = 4'd5,
        CMD_NOT_A   = 4'd6,
        CMD_NOT_B   = 4'd7,
        CMD_SHR1_A  = 4'd8,
        CMD_SHL1_A  = 4'd9,
        CMD_SHR1_B  = 4'd10,
        CMD_SHL1_B  = 4'd11,
        CMD_ROL_A_B = 4'd12,
        CMD_ROR_A_B = 4'd13
    } logic_cmd_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT_A,
        ST_WAIT_B,
        ST_MUL
    } state_e;

    // Which operands a command consumes; OPS_NONE marks an invalid command.
    typedef enum logic [1:0] {
        OPS_NONE,
        OPS_A,
        OPS_B,
        OPS_AB
    } ops_e;

    function automatic ops_e cmd_operands(input logic mode, input cmd_t cmd);
        ops_e ops;
        ops = OPS_NONE;
        if (mode) begin
            case (cmd)
                CMD_ADD, CMD_SUB, CMD_ADD_CIN, CMD_SUB_CIN,
                CMD_CMP, CMD_MUL_INC, CMD_MUL_SHL:          ops = OPS_AB;
                CMD_INC_A, CMD_DEC_A:                       ops = OPS_A;
                CMD_INC_B, CMD_DEC_B:                       ops = OPS_B;
                default:                                    ops = OPS_NONE;
            endcase
        end else begin
            case (cmd)
                CMD_AND, CMD_NAND, CMD_OR, CMD_NOR, CMD_XOR,
                CMD_XNOR, CMD_ROL_A_B, CMD_ROR_A_B:         ops = OPS_AB;
                CMD_NOT_A, CMD_SHR1_A, CMD_SHL1_A:          ops = OPS_A;
                CMD_NOT_B, CMD_SHR1_B, CMD_SHL1_B:          ops = OPS_B;
                default:                                    ops = OPS_NONE;
            endcase
        end
        return ops;
    endfunction

    function automatic logic cmd_is_mul(input logic mode, input cmd_t cmd);
        return mode && (cmd == CMD_MUL_INC || cmd == CMD_MUL_SHL);
    endfunction

endpackage

// File: rtl/alu_operand_collector.sv
// Operand collection: gathers OPA/OPB (possibly on different cycles), times
// out a missing operand, and marks the busy cycle of a multiply.
//
// state      | meaning
// -----------+----------------------------------------------------------
// ST_IDLE    | ready for a new command
// ST_WAIT_A  | OPB and command latched, waiting for OPA
// ST_WAIT_B  | OPA and command latched, waiting for OPB
// ST_MUL     | multiply in flight, inputs ignored this cycle
module alu_operand_collector
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int CMD_WIDTH  = CMD_WIDTH_DEF
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  ce_i,
    input  logic                  mode_i,
    input  logic [CMD_WIDTH-1:0]  cmd_i,
    input  logic [1:0]            inp_valid_i,
    input  logic [DATA_WIDTH-1:0] opa_i,
    input  logic [DATA_WIDTH-1:0] opb_i,
    input  logic                  cin_i,
    output logic                  issue_o,
    output logic                  err_o,
    output logic                  mul_fire_o,
    output logic                  iss_mode_o,
    output cmd_t                  iss_cmd_o,
    output logic                  iss_cin_o,
    output logic [DATA_WIDTH-1:0] iss_a_o,
    output logic [DATA_WIDTH-1:0] iss_b_o
);

    state_e                  state_q, state_d;
    logic [WAIT_CNT_W-1:0]   cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]   a_q, a_d, b_q, b_d;
    logic                    mode_q, mode_d, cin_q, cin_d;
    cmd_t                    cmd_q, cmd_d;

    cmd_t                    cmd_lo;
    logic                    cmd_hi;
    ops_e                    ops;

    // Command codes wider than the enum range are always invalid.
    assign cmd_lo = cmd_i[CMD_WIDTH_DEF-1:0];
    assign cmd_hi = |(cmd_i >> CMD_WIDTH_DEF);
    assign ops    = cmd_hi ? OPS_NONE : cmd_operands(mode_i, cmd_lo);

    // Next-state, latch updates and issue/error strobes.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        a_d        = a_q;
        b_d        = b_q;
        mode_d     = mode_q;
        cmd_d      = cmd_q;
        cin_d      = cin_q;
        issue_o    = 1'b0;
        err_o      = 1'b0;
        mul_fire_o = 1'b0;
        iss_mode_o = mode_i;
        iss_cmd_o  = cmd_lo;
        iss_cin_o  = cin_i;
        iss_a_o    = opa_i;
        iss_b_o    = opb_i;

        if (ce_i) begin
            unique case (state_q)
                ST_IDLE: begin
                    case (ops)
                        OPS_NONE: err_o = 1'b1;
                        OPS_A: begin
                            if (inp_valid_i[0]) issue_o = 1'b1;
                            else                err_o   = 1'b1;
                        end
                        OPS_B: begin
                            if (inp_valid_i[1]) issue_o = 1'b1;
                            else                err_o   = 1'b1;
                        end
                        OPS_AB: begin
                            case (inp_valid_i)
                                2'b11: issue_o = 1'b1;
                                2'b01: begin
                                    a_d     = opa_i;
                                    mode_d  = mode_i;
                                    cmd_d   = cmd_lo;
                                    cin_d   = cin_i;
                                    cnt_d   = '0;
                                    state_d = ST_WAIT_B;
                                end
                                2'b10: begin
                                    b_d     = opb_i;
                                    mode_d  = mode_i;
                                    cmd_d   = cmd_lo;
                                    cin_d   = cin_i;
                                    cnt_d   = '0;
                                    state_d = ST_WAIT_A;
                                end
                                default: ;
                            endcase
                        end
                        default: ;
                    endcase
                    if (issue_o && cmd_is_mul(mode_i, cmd_lo)) state_d = ST_MUL;
                end

                ST_WAIT_A, ST_WAIT_B: begin
                    iss_mode_o = mode_q;
                    iss_cmd_o  = cmd_q;
                    iss_cin_o  = cin_q;
                    if (state_q == ST_WAIT_A) iss_b_o = b_q;
                    else                      iss_a_o = a_q;
                    if ((state_q == ST_WAIT_A) ? inp_valid_i[0] : inp_valid_i[1]) begin
                        issue_o = 1'b1;
                        cnt_d   = '0;
                        state_d = cmd_is_mul(mode_q, cmd_q) ? ST_MUL : ST_IDLE;
                    end else if (cnt_q == WAIT_CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        err_o   = 1'b1;
                        cnt_d   = '0;
                        state_d = ST_IDLE;
                    end else begin
                        cnt_d = cnt_q + WAIT_CNT_W'(1);
                    end
                end

                ST_MUL: begin
                    mul_fire_o = 1'b1;
                    state_d    = ST_IDLE;
                end

                default: state_d = ST_IDLE;
            endcase
        end
    end

    // State, wait counter and operand latches; frozen while CE is low.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            mode_q  <= 1'b0;
            cmd_q   <= '0;
            cin_q   <= 1'b0;
        end else if (ce_i) begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            mode_q  <= mode_d;
            cmd_q   <= cmd_d;
            cin_q   <= cin_d;
        end
    end

endmodule

// File: rtl/alu_core.sv
// ALU top: arithmetic/logical datapath, two-cycle multiply and registered
// outputs. Outputs float while RESET is held and read 0 after release
// until the first result lands.
module alu_core
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int CMD_WIDTH  = CMD_WIDTH_DEF
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  CE,
    input  logic                  MODE,
    input  logic [CMD_WIDTH-1:0]  CMD,
    input  logic [1:0]            INP_VALID,
    input  logic [DATA_WIDTH-1:0] OPA,
    input  logic [DATA_WIDTH-1:0] OPB,
    input  logic                  CIN,
    output logic [DATA_WIDTH+1:0] RES,
    output logic                  COUT,
    output logic                  OFLOW,
    output logic                  ERR,
    output logic                  E,
    output logic                  G,
    output logic                  L
);

    localparam int RW   = DATA_WIDTH + 2;
    localparam int SH_W = $clog2(DATA_WIDTH);

    logic                  issue, err, mul_fire, iss_mode, iss_cin;
    cmd_t                  iss_cmd;
    logic [DATA_WIDTH-1:0] iss_a, iss_b;

    logic [RW-1:0]         res_q, res_d;
    logic                  cout_q, cout_d, oflow_q, oflow_d, err_q, err_d;
    logic                  e_q, e_d, g_q, g_d, l_q, l_d;
    logic                  out_en_q;
    logic [DATA_WIDTH:0]   mul_a_q, mul_a_d, mul_b_q, mul_b_d;
    logic [2*DATA_WIDTH+1:0] prod;

    logic [RW-1:0]           a_x, b_x, cin_x;
    logic [DATA_WIDTH-1:0]   lres;
    logic [2*DATA_WIDTH-1:0] rot;
    logic [SH_W-1:0]         sh;

    alu_operand_collector #(
        .DATA_WIDTH (DATA_WIDTH),
        .CMD_WIDTH  (CMD_WIDTH)
    ) u_collector (
        .clk_i       (CLK),
        .rst_i       (RESET),
        .ce_i        (CE),
        .mode_i      (MODE),
        .cmd_i       (CMD),
        .inp_valid_i (INP_VALID),
        .opa_i       (OPA),
        .opb_i       (OPB),
        .cin_i       (CIN),
        .issue_o     (issue),
        .err_o       (err),
        .mul_fire_o  (mul_fire),
        .iss_mode_o  (iss_mode),
        .iss_cmd_o   (iss_cmd),
        .iss_cin_o   (iss_cin),
        .iss_a_o     (iss_a),
        .iss_b_o     (iss_b)
    );

    // Product of the multiplicands staged on the issue cycle; kept modulo RES width.
    assign prod = {{(DATA_WIDTH+1){1'b0}}, mul_a_q} * {{(DATA_WIDTH+1){1'b0}}, mul_b_q};

    // Next output values from the issued command, an error, or a landing product.
    always_comb begin
        res_d   = res_q;
        cout_d  = cout_q;
        oflow_d = oflow_q;
        err_d   = err_q;
        e_d     = e_q;
        g_d     = g_q;
        l_d     = l_q;
        mul_a_d = mul_a_q;
        mul_b_d = mul_b_q;
        a_x     = RW'(iss_a);
        b_x     = RW'(iss_b);
        cin_x   = RW'(iss_cin);
        sh      = iss_b[SH_W-1:0];
        rot     = '0;
        lres    = '0;

        if (mul_fire) begin
            res_d   = prod[RW-1:0];
            {cout_d, oflow_d, err_d, e_d, g_d, l_d} = '0;
        end else if (err) begin
            res_d   = '0;
            {cout_d, oflow_d, e_d, g_d, l_d} = '0;
            err_d   = 1'b1;
        end else if (issue) begin
            if (cmd_is_mul(iss_mode, iss_cmd)) begin
                // Outputs hold; only the multiplicands are staged.
                mul_a_d = (iss_cmd == CMD_MUL_INC) ? ({1'b0, iss_a} + (DATA_WIDTH+1)'(1))
                                                   : {iss_a, 1'b0};
                mul_b_d = (iss_cmd == CMD_MUL_INC) ? ({1'b0, iss_b} + (DATA_WIDTH+1)'(1))
                                                   : {1'b0, iss_b};
            end else begin
                res_d = '0;
                {cout_d, oflow_d, err_d, e_d, g_d, l_d} = '0;
                if (iss_mode) begin
                    case (iss_cmd)
                        CMD_ADD:     begin res_d = a_x + b_x;         cout_d  = res_d[DATA_WIDTH]; end
                        CMD_ADD_CIN: begin res_d = a_x + b_x + cin_x; cout_d  = res_d[DATA_WIDTH]; end
                        CMD_SUB:     begin res_d = a_x - b_x;         oflow_d = (a_x < b_x); end
                        CMD_SUB_CIN: begin res_d = a_x - b_x - cin_x; oflow_d = (a_x < b_x + cin_x); end
                        CMD_INC_A:   begin res_d = a_x + RW'(1);      cout_d  = res_d[DATA_WIDTH]; end
                        CMD_DEC_A:   begin res_d = a_x - RW'(1);      oflow_d = (iss_a == '0); end
                        CMD_INC_B:   begin res_d = b_x + RW'(1);      cout_d  = res_d[DATA_WIDTH]; end
                        CMD_DEC_B:   begin res_d = b_x - RW'(1);      oflow_d = (iss_b == '0); end
                        CMD_CMP: begin
                            e_d = (iss_a == iss_b);
                            g_d = (iss_a >  iss_b);
                            l_d = (iss_a <  iss_b);
                        end
                        default: ;
                    endcase
                end else begin
                    case (iss_cmd)
                        CMD_AND:    lres = iss_a & iss_b;
                        CMD_NAND:   lres = ~(iss_a & iss_b);
                        CMD_OR:     lres = iss_a | iss_b;
                        CMD_NOR:    lres = ~(iss_a | iss_b);
                        CMD_XOR:    lres = iss_a ^ iss_b;
                        CMD_XNOR:   lres = ~(iss_a ^ iss_b);
                        CMD_NOT_A:  lres = ~iss_a;
                        CMD_NOT_B:  lres = ~iss_b;
                        CMD_SHR1_A: lres = iss_a >> 1;
                        CMD_SHL1_A: lres = iss_a << 1;
                        CMD_SHR1_B: lres = iss_b >> 1;
                        CMD_SHL1_B: lres = iss_b << 1;
                        CMD_ROL_A_B: begin
                            rot   = {iss_a, iss_a} << sh;
                            lres  = rot[2*DATA_WIDTH-1:DATA_WIDTH];
                            err_d = |(iss_b >> SH_W);
                        end
                        CMD_ROR_A_B: begin
                            rot   = {iss_a, iss_a} >> sh;
                            lres  = rot[DATA_WIDTH-1:0];
                            err_d = |(iss_b >> SH_W);
                        end
                        default: ;
                    endcase
                    res_d = RW'(lres);
                end
            end
        end
    end

    // Output and multiply-stage registers; reset floats the pins until release.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            res_q    <= '0;
            cout_q   <= 1'b0;
            oflow_q  <= 1'b0;
            err_q    <= 1'b0;
            e_q      <= 1'b0;
            g_q      <= 1'b0;
            l_q      <= 1'b0;
            mul_a_q  <= '0;
            mul_b_q  <= '0;
            out_en_q <= 1'b0;
        end else begin
            out_en_q <= 1'b1;
            if (CE) begin
                res_q   <= res_d;
                cout_q  <= cout_d;
                oflow_q <= oflow_d;
                err_q   <= err_d;
                e_q     <= e_d;
                g_q     <= g_d;
                l_q     <= l_d;
                mul_a_q <= mul_a_d;
                mul_b_q <= mul_b_d;
            end
        end
    end

    assign RES   = out_en_q ? res_q   : 'z;
    assign COUT  = out_en_q ? cout_q  : 1'bz;
    assign OFLOW = out_en_q ? oflow_q : 1'bz;
    assign ERR   = out_en_q ? err_q   : 1'bz;
    assign E     = out_en_q ? e_q     : 1'bz;
    assign G     = out_en_q ? g_q     : 1'bz;
    assign L     = out_en_q ? l_q     : 1'bz;

endmodule

// File: doc/alu_core.md
ALU_CORE -- requirements
Module: alu_core

Interface
REQ-001 Parameter DATA_WIDTH, default 8, operand width.
REQ-002 Parameter CMD_WIDTH, default 4, command width.
REQ-003 CLK  input  1  sole clock; all state updates on posedge CLK.
REQ-004 RESET  input  1  synchronous, active-high reset, sampled on posedge CLK.
REQ-005 CE  input  1  clock enable; 0 freezes all state and outputs.
REQ-006 MODE  input  1  1 = arithmetic command set, 0 = logical command set.
REQ-007 CMD  input  CMD_WIDTH  operation select.
REQ-008 INP_VALID  input  2  bit0 = OPA valid, bit1 = OPB valid.
REQ-009 OPA, OPB  input  DATA_WIDTH each  operands.
REQ-010 CIN  input  1  carry/borrow in for ADD_CIN/SUB_CIN.
REQ-011 RES  output  DATA_WIDTH+2  registered result, zero-extended.
REQ-012 COUT, OFLOW, ERR, E, G, L  output  1 each  carry, overflow/borrow, error, equal, greater, less.

Function
REQ-013 Arithmetic CMD (MODE=1): 0 ADD, 1 SUB, 2 ADD_CIN, 3 SUB_CIN, 4 INC_A, 5 DEC_A, 6 INC_B, 7 DEC_B, 8 CMP, 9 MUL_INC ((A+1)*(B+1)), 10 MUL_SHL ((A<<1)*B); CMD>10 invalid.
REQ-014 Logical CMD (MODE=0): 0 AND, 1 NAND, 2 OR, 3 NOR, 4 XOR, 5 XNOR, 6 NOT_A, 7 NOT_B, 8 SHR1_A, 9 SHL1_A, 10 SHR1_B, 11 SHL1_B, 12 ROL_A_B, 13 ROR_A_B; CMD>13 invalid.
REQ-015 Invalid CMD accepted with CE=1 and RESET=0 -> ERR=1, RES=0, other flags 0 on the next posedge.
REQ-016 Non-multiply results/flags appear exactly one cycle after operand completion; MUL_INC/MUL_SHL after two cycles.
REQ-017 During a multiply's second cycle the block is busy; inputs sampled that cycle are ignored; outputs hold the previous value until the product lands.
REQ-018 ADD/ADD_CIN/INC: COUT = carry out of bit DATA_WIDTH-1, RES holds full sum; SUB/SUB_CIN/DEC: OFLOW=1 on borrow (A<B+cin), RES = modulo 2^(DATA_WIDTH+2) difference.
REQ-019 CMP: exactly one of E/G/L set (unsigned A vs B), RES=0; E/G/L are 0 for all other commands.
REQ-020 Logical results occupy RES[DATA_WIDTH-1:0], upper bits 0, COUT=OFLOW=0.
REQ-021 ROL/ROR rotate OPA by OPB[$clog2(DATA_WIDTH)-1:0]; any higher OPB bit set -> ERR=1 alongside the rotated result.
REQ-022 Operand-collection FSM states IDLE, WAIT_A, WAIT_B, MUL.
REQ-023 IDLE, two-operand cmd, INP_VALID=11 -> compute; =01 -> latch OPA+cmd, go WAIT_B; =10 -> latch OPB+cmd, go WAIT_A; =00 -> stay, outputs hold.
REQ-024 WAIT_x: wait counter increments each CE=1 cycle; missing operand arrives (its INP_VALID bit set) within 16 cycles -> compute with latched cmd, go IDLE (or MUL).
REQ-025 WAIT_x: 16 cycles without the missing operand -> ERR=1, RES=0, go IDLE; counter clears.
REQ-026 Single-operand cmds (INC/DEC/NOT/SHx) require only their operand bit; bit absent -> ERR=1 next cycle.
REQ-027 CE=0 in any state: FSM, counter, latched operands and outputs frozen; counter does not advance.

Reset
REQ-028 RESET high at posedge: FSM -> IDLE, counter and latches -> 0, all outputs driven to high impedance ('z) while RESET remains high.
REQ-029 RESET overrides CE and aborts any WAIT_x or MUL in flight; no ERR or result emitted for the aborted operation.
REQ-030 First posedge with RESET low -> outputs 0 until the first result.

Structure
REQ-031 Package alu_pkg holds DATA_WIDTH/CMD_WIDTH defaults, arith/logic command enums, FSM state enum, timeout constant 16.
REQ-032 Sub-module alu_operand_collector implements FSM, wait counter and operand latches; alu_core holds datapath and output registers.

Verification
REQ-033 MODE=1 CMD=0 OPA=8'hFF OPB=8'h01 INP_VALID=11 -> next cycle RES=10'h100, COUT=1, ERR=0.
REQ-034 MODE=1 CMD=9 OPA=3 OPB=4 INP_VALID=11 -> RES=20 two cycles later; input changes in the busy cycle ignored.
REQ-035 MODE=0 CMD=14 -> ERR=1 next cycle; MODE=1 CMD=11 -> ERR=1 next cycle.
REQ-036 MODE=1 CMD=1 INP_VALID=01 OPA=5, then INP_VALID=00 for 16 cycles -> ERR=1, RES=0; repeat with OPB=7 arriving at cycle 10 -> RES=-2 mod 2^10, OFLOW=1.
REQ-037 RESET asserted in WAIT_B -> outputs 'z, FSM IDLE; after release, CMP OPA=OPB=9 -> E=1, G=L=0.
REQ-038 CE=0 for 5 cycles mid-WAIT_A -> timeout extended by exactly 5 cycles.
